// File: rtl/spio_hss_multiplexer_rx_aligner.sv
// ============================================================================
// Module   : spio_hss_multiplexer_rx_aligner
// Purpose  : Rotates the 32-bit GTP receive stream so that commas land in
//            byte lane 0, locking onto a consistent comma lane and reporting
//            loss of sync downstream until alignment is established.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spio_hss_multiplexer_rx_aligner #(
  parameter int LOCK_COUNT    = 4,
  parameter int UNLOCK_ERRORS = 4,
  parameter int COUNT_BITS    = 3
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [31:0] RAW_RXDATA_IN,
  input  logic [3:0]  RAW_RXCHARISCOMMA_IN,
  input  logic [3:0]  RAW_RXCHARISK_IN,
  input  logic [1:0]  RAW_RXLOSSOFSYNC_IN,
  output logic [31:0] RXDATA_OUT,
  output logic [3:0]  RXCHARISCOMMA_OUT,
  output logic [3:0]  RXCHARISK_OUT,
  output logic [1:0]  RXLOSSOFSYNC_OUT,
  output logic        ALIGNED_OUT,
  output logic [1:0]  ALIGNMENT_OUT
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Two-word pipeline: r1 holds the newest word, r2 the one before it.
  logic [31:0] r1_data, r2_data;
  logic [3:0]  r1_comma, r2_comma;
  logic [3:0]  r1_k, r2_k;
  logic [1:0]  r1_los, r2_los;

  state_t                state;
  logic [1:0]            cand;
  logic [1:0]            offset;
  logic [COUNT_BITS-1:0] cnt;
  logic [COUNT_BITS-1:0] err;

  logic [1:0]            lane;
  logic [COUNT_BITS-1:0] cnt_inc;
  logic [COUNT_BITS-1:0] err_inc;
  logic [31:0]           data_sel;
  logic [3:0]            comma_sel;
  logic [3:0]            k_sel;

  // Lowest comma lane in the newest word; upper commas in the same word are ignored.
  always_comb begin
    lane = 2'd0;
    if (r1_comma[0])      lane = 2'd0;
    else if (r1_comma[1]) lane = 2'd1;
    else if (r1_comma[2]) lane = 2'd2;
    else if (r1_comma[3]) lane = 2'd3;
  end

  // Saturating increments so neither counter can wrap back below its threshold.
  always_comb begin
    cnt_inc = (cnt == {COUNT_BITS{1'b1}}) ? cnt : cnt + 1'b1;
    err_inc = (err == {COUNT_BITS{1'b1}}) ? err : err + 1'b1;
  end

  // 8-byte window (r2 = bytes 0-3, r1 = bytes 4-7) shifted down by the lane offset.
  always_comb begin
    data_sel  = 32'({r1_data, r2_data} >> {offset, 3'b000});
    comma_sel = 4'({r1_comma, r2_comma} >> offset);
    k_sel     = 4'({r1_k, r2_k} >> offset);
  end

  // Input pipeline registers.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r1_data  <= '0;
      r1_comma <= '0;
      r1_k     <= '0;
      r1_los   <= '0;
      r2_data  <= '0;
      r2_comma <= '0;
      r2_k     <= '0;
      r2_los   <= '0;
    end else begin
      r1_data  <= RAW_RXDATA_IN;
      r1_comma <= RAW_RXCHARISCOMMA_IN;
      r1_k     <= RAW_RXCHARISK_IN;
      r1_los   <= RAW_RXLOSSOFSYNC_IN;
      r2_data  <= r1_data;
      r2_comma <= r1_comma;
      r2_k     <= r1_k;
      r2_los   <= r1_los;
    end
  end

  // Alignment FSM: hunt for a comma lane, verify it repeats, then hold it
  // until enough consecutive foreign-lane commas or a GTP loss of sync.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state  <= HUNT;
      cand   <= 2'd0;
      offset <= 2'd0;
      cnt    <= '0;
      err    <= '0;
    end else if (r1_los[1]) begin
      // GTP loss of sync wins over any comma seen in the same word.
      state <= HUNT;
      cnt   <= '0;
      err   <= '0;
    end else if (|r1_comma) begin
      case (state)
        HUNT: begin
          cand <= lane;
          cnt  <= COUNT_BITS'(1);
          if (LOCK_COUNT == 1) begin
            state  <= LOCKED;
            offset <= lane;
            err    <= '0;
          end else begin
            state <= VERIFY;
          end
        end
        VERIFY: begin
          if (lane == cand) begin
            cnt <= cnt_inc;
            if (cnt_inc >= COUNT_BITS'(LOCK_COUNT)) begin
              state  <= LOCKED;
              offset <= cand;
              err    <= '0;
            end
          end else begin
            cand <= lane;
            cnt  <= COUNT_BITS'(1);
          end
        end
        LOCKED: begin
          if (lane == offset) begin
            err <= '0;
          end else if (err_inc >= COUNT_BITS'(UNLOCK_ERRORS)) begin
            // Offset is kept so data keeps flowing in the old alignment.
            state <= HUNT;
            cnt   <= '0;
            err   <= '0;
          end else begin
            err <= err_inc;
          end
        end
        default: begin
          state <= HUNT;
          cnt   <= '0;
          err   <= '0;
        end
      endcase
    end
  end

  // Registered outputs; status uses the same offset/state as the data mux.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      RXDATA_OUT        <= '0;
      RXCHARISCOMMA_OUT <= '0;
      RXCHARISK_OUT     <= '0;
      RXLOSSOFSYNC_OUT  <= 2'b10;
      ALIGNED_OUT       <= 1'b0;
      ALIGNMENT_OUT     <= 2'd0;
    end else begin
      RXDATA_OUT        <= data_sel;
      RXCHARISCOMMA_OUT <= comma_sel;
      RXCHARISK_OUT     <= k_sel;
      RXLOSSOFSYNC_OUT  <= {(state != LOCKED) | r2_los[1], r2_los[0]};
      ALIGNED_OUT       <= (state == LOCKED);
      ALIGNMENT_OUT     <= offset;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_rx_aligner.sv
// ============================================================================
// Module   : tb_spio_hss_multiplexer_rx_aligner
// Purpose  : Scoreboard bench for the RX comma aligner with a word-level
//            reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spio_hss_multiplexer_rx_aligner;

  localparam int LOCK_COUNT    = 4;
  localparam int UNLOCK_ERRORS = 4;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic [31:0] RAW_RXDATA_IN;
  logic [3:0]  RAW_RXCHARISCOMMA_IN;
  logic [3:0]  RAW_RXCHARISK_IN;
  logic [1:0]  RAW_RXLOSSOFSYNC_IN;
  logic [31:0] RXDATA_OUT;
  logic [3:0]  RXCHARISCOMMA_OUT;
  logic [3:0]  RXCHARISK_OUT;
  logic [1:0]  RXLOSSOFSYNC_OUT;
  logic        ALIGNED_OUT;
  logic [1:0]  ALIGNMENT_OUT;

  spio_hss_multiplexer_rx_aligner #(
    .LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRORS(UNLOCK_ERRORS), .COUNT_BITS(3)
  ) dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN),
    .RAW_RXDATA_IN(RAW_RXDATA_IN), .RAW_RXCHARISCOMMA_IN(RAW_RXCHARISCOMMA_IN),
    .RAW_RXCHARISK_IN(RAW_RXCHARISK_IN), .RAW_RXLOSSOFSYNC_IN(RAW_RXLOSSOFSYNC_IN),
    .RXDATA_OUT(RXDATA_OUT), .RXCHARISCOMMA_OUT(RXCHARISCOMMA_OUT),
    .RXCHARISK_OUT(RXCHARISK_OUT), .RXLOSSOFSYNC_OUT(RXLOSSOFSYNC_OUT),
    .ALIGNED_OUT(ALIGNED_OUT), .ALIGNMENT_OUT(ALIGNMENT_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic [3:0]  k;
    logic [1:0]  los;
  } word_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic [3:0]  k;
    logic [1:0]  los;
    logic        al;
    logic [1:0]  off;
  } exp_t;

  exp_t  q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    run      = 1'b0;
  bit    rnd_data = 1'b0;
  logic [7:0] seq_byte = 8'h00;
  word_t prev;
  word_t zero_w;

  // Reference model: "locked" flag, lane in use, length of the current
  // same-lane comma run while hunting, and length of the foreign run while locked.
  int m_locked = 0;
  int m_off    = 0;
  int m_cand   = 0;
  int m_run    = 0;
  int m_miss   = 0;

  function automatic int low_lane(logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_step(word_t w);
    int l;
    l = low_lane(w.c);
    if (w.los[1]) begin
      m_locked = 0; m_run = 0; m_miss = 0;
    end else if (l >= 0) begin
      if (m_locked == 0) begin
        if (m_run > 0 && l == m_cand) m_run = m_run + 1;
        else begin m_cand = l; m_run = 1; end
        if (m_run >= LOCK_COUNT) begin
          m_locked = 1; m_off = m_cand; m_miss = 0;
        end
      end else begin
        if (l == m_off) m_miss = 0;
        else m_miss = m_miss + 1;
        if (m_miss >= UNLOCK_ERRORS) begin
          m_locked = 0; m_run = 0; m_miss = 0;
        end
      end
    end
  endtask

  // Output expected while word p is the older half of the byte window and x the newer.
  function automatic exp_t make_exp(word_t p, word_t x);
    logic [63:0] wd;
    logic [7:0]  wc, wk;
    exp_t e;
    wd = {x.d, p.d};
    wc = {x.c, p.c};
    wk = {x.k, p.k};
    for (int j = 0; j < 4; j++) begin
      e.d[8*j +: 8] = wd[8*(m_off+j) +: 8];
      e.c[j] = wc[m_off+j];
      e.k[j] = wk[m_off+j];
    end
    e.los = {(m_locked == 0) | p.los[1], p.los[0]};
    e.al  = (m_locked != 0);
    e.off = 2'(m_off);
    return e;
  endfunction

  function automatic word_t mk(logic [3:0] mask, logic [1:0] los);
    word_t w;
    if (rnd_data) w.d = $urandom;
    else begin
      w.d = {seq_byte + 8'd3, seq_byte + 8'd2, seq_byte + 8'd1, seq_byte};
      seq_byte = seq_byte + 8'd4;
    end
    for (int i = 0; i < 4; i++) if (mask[i]) w.d[8*i +: 8] = 8'hBC;
    w.c   = mask;
    w.k   = mask | (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0);
    w.los = los;
    return w;
  endfunction

  task automatic apply(word_t x);
    model_step(prev);
    q.push_back(make_exp(prev, x));
    prev = x;
    RAW_RXDATA_IN        = x.d;
    RAW_RXCHARISCOMMA_IN = x.c;
    RAW_RXCHARISK_IN     = x.k;
    RAW_RXLOSSOFSYNC_IN  = x.los;
  endtask

  task automatic send(word_t x);
    @(negedge CLK_IN);
    apply(x);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) send(mk(4'b0, 2'b00));
  endtask

  // Each comma word is followed by three plain words.
  task automatic commas(logic [3:0] mask, int n);
    for (int i = 0; i < n; i++) begin
      send(mk(mask, 2'b00));
      idle(3);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the block emits a word every cycle, so every cycle pops one expectation.
  initial begin
    forever begin
      @(posedge CLK_IN);
      #1;
      if (run) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_underflow: got output with no expectation, expected queued entry");
        end else begin
          exp_t e;
          exp_t a;
          e = q.pop_front();
          a = {RXDATA_OUT, RXCHARISCOMMA_OUT, RXCHARISK_OUT, RXLOSSOFSYNC_OUT,
               ALIGNED_OUT, ALIGNMENT_OUT};
          if (a !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t: got d=%h c=%b k=%b los=%b al=%b off=%0d expected d=%h c=%b k=%b los=%b al=%b off=%0d",
                     $time, a.d, a.c, a.k, a.los, a.al, a.off, e.d, e.c, e.k, e.los, e.al, e.off);
          end
        end
      end
    end
  end

  initial begin
    zero_w = '{d: 32'h0, c: 4'h0, k: 4'h0, los: 2'b00};
    prev   = zero_w;
    RESET_IN = 1'b0;
    RAW_RXDATA_IN = '0; RAW_RXCHARISCOMMA_IN = '0; RAW_RXCHARISK_IN = '0; RAW_RXLOSSOFSYNC_IN = '0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK_IN);
      RAW_RXDATA_IN        = $urandom;
      RAW_RXCHARISCOMMA_IN = 4'($urandom);
      RAW_RXCHARISK_IN     = 4'($urandom);
      RAW_RXLOSSOFSYNC_IN  = 2'($urandom);
      chk("reset_data", RXDATA_OUT, 32'h0);
      chk("reset_comma_k", {24'h0, RXCHARISCOMMA_OUT, RXCHARISK_OUT}, 32'h0);
      chk("reset_los", {30'h0, RXLOSSOFSYNC_OUT}, 32'h2);
      chk("reset_aligned", {29'h0, ALIGNED_OUT, ALIGNMENT_OUT}, 32'h0);
    end

    // Release: the window starts from two cleared pipeline words.
    @(negedge CLK_IN);
    RESET_IN = 1'b1;
    q.push_back(make_exp(zero_w, zero_w));
    run = 1'b1;
    apply(zero_w);
    for (int i = 0; i < 5; i++) send(zero_w);
    chk("post_reset_data", RXDATA_OUT, 32'h0);
    chk("post_reset_los", {30'h0, RXLOSSOFSYNC_OUT}, 32'h2);
    chk("post_reset_aligned", {31'h0, ALIGNED_OUT}, 32'h0);

    // Lock on lane 2 with incrementing data.
    commas(4'b0100, 3);
    chk("lane2_not_yet", {31'h0, ALIGNED_OUT}, 32'h0);
    commas(4'b0100, 3);
    chk("lane2_aligned", {31'h0, ALIGNED_OUT}, 32'h1);
    chk("lane2_offset", {30'h0, ALIGNMENT_OUT}, 32'h2);

    // GTP loss of sync together with a valid comma forces a full re-hunt.
    send(mk(4'b0100, 2'b10));
    idle(4);
    chk("los_unlocked", {31'h0, ALIGNED_OUT}, 32'h0);
    commas(4'b0100, 3);
    chk("los_relock_partial", {31'h0, ALIGNED_OUT}, 32'h0);
    commas(4'b0100, 1);
    chk("los_relocked", {31'h0, ALIGNED_OUT}, 32'h1);

    // Competing lanes 1 and 3 never lock, then lane 3 wins.
    for (int i = 0; i < 5; i++) begin
      commas(4'b0010, 1);
      commas(4'b1000, 1);
    end
    chk("compete_unlocked", {31'h0, ALIGNED_OUT}, 32'h0);
    commas(4'b1000, 4);
    chk("lane3_aligned", {31'h0, ALIGNED_OUT}, 32'h1);
    chk("lane3_offset", {30'h0, ALIGNMENT_OUT}, 32'h3);

    // Move to lane 0: four foreign commas unlock, four more lock.
    commas(4'b0001, 8);
    chk("lane0_offset", {29'h0, ALIGNED_OUT, ALIGNMENT_OUT}, 32'h4);

    // Foreign run broken by a lane-0 comma keeps the lock.
    commas(4'b0010, 3);
    commas(4'b0001, 1);
    commas(4'b0010, 3);
    chk("unlock_held", {31'h0, ALIGNED_OUT}, 32'h1);
    commas(4'b0010, 1);
    chk("unlock_dropped", {31'h0, ALIGNED_OUT}, 32'h0);
    chk("unlock_los", {31'h0, RXLOSSOFSYNC_OUT[1]}, 32'h1);

    // Two commas per word: the lower lane is the candidate.
    commas(4'b1010, 4);
    chk("multi_offset", {29'h0, ALIGNED_OUT, ALIGNMENT_OUT}, 32'h5);

    // Randomized traffic with a drifting preferred comma lane.
    rnd_data = 1'b1;
    begin
      int fav;
      fav = 0;
      for (int i = 0; i < 400; i++) begin
        logic [3:0] mask;
        logic [1:0] los;
        if ($urandom_range(0, 59) == 0) fav = $urandom_range(0, 3);
        mask = 4'b0;
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 4) != 0) mask = 4'(1 << fav);
          else mask = 4'($urandom_range(1, 15));
        end
        los = {($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1))};
        send(mk(mask, los));
      end
    end
    idle(3);

    @(negedge CLK_IN);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spio_hss_multiplexer_rx_aligner.md
Name: spio_hss_multiplexer_rx_aligner

Overview:
Sits between the Spartan-6 GTP receiver and the RX side of the HSS multiplexer. It rotates the 32-bit receive stream so that every comma character lands in byte lane 0. The multiplexer's framing logic relies on this lane placement. The block locks onto a consistent comma lane, tracks misaligned commas, and reports loss of sync downstream until alignment is established.

Parameters:
LOCK_COUNT, 4, consecutive commas in the same lane required to lock (1..7)
UNLOCK_ERRORS, 4, consecutive commas in a foreign lane that force re-hunt (1..7)
COUNT_BITS, 3, width of both counters

Ports:
CLK_IN  in  1  receive word clock
RESET_IN  in  1  asynchronous, active-low reset
RAW_RXDATA_IN  in  32  GTP receive data; lane k = bits [8k+7:8k]
RAW_RXCHARISCOMMA_IN  in  4  per-lane comma flag
RAW_RXCHARISK_IN  in  4  per-lane K-character flag
RAW_RXLOSSOFSYNC_IN  in  2  GTP loss-of-sync status
RXDATA_OUT  out  32  lane-aligned data, to multiplexer RXDATA_IN
RXCHARISCOMMA_OUT  out  4  lane-aligned comma flags
RXCHARISK_OUT  out  4  lane-aligned K flags
RXLOSSOFSYNC_OUT  out  2  to multiplexer RXLOSSOFSYNC_IN
ALIGNED_OUT  out  1  high while LOCKED
ALIGNMENT_OUT  out  2  current lane offset in use

Behaviour:
- Reset: asynchronous and active-low. It affects all registers.
  - State = HUNT, offset = 0, both counters = 0.
  - Pipeline registers R1 and R2 are cleared.
  - Outputs after reset: RXDATA/COMMA/K = 0, RXLOSSOFSYNC_OUT = 2'b10, ALIGNED_OUT = 0, ALIGNMENT_OUT = 0.
- Pipeline:
  - Each cycle, raw data/comma/K flags enter R1, and R1 shifts into R2.
  - The window is 8 bytes: bytes 0-3 come from R2, bytes 4-7 from R1.
  - Output byte j (with its comma and K flags) = window byte (offset + j), registered.
  - Latency: a raw word whose comma is in lane o appears with that comma in RXDATA_OUT lane 0 exactly 3 cycles later, when offset = o.
- Detection:
  - The candidate lane is the lowest set bit of R1's comma flags.
  - If a word contains several commas, only the lowest lane counts.
  - A word with no comma is neutral in every state.
- FSM:
  - HUNT: on a comma, cand <= lane, cnt <= 1, go to VERIFY. If LOCK_COUNT = 1, go directly to LOCKED with offset <= lane.
  - VERIFY, comma in cand: cnt++. When cnt reaches LOCK_COUNT, go to LOCKED, offset <= cand, err <= 0.
  - VERIFY, comma in another lane: cand <= new lane, cnt <= 1.
  - LOCKED, comma in offset lane: err <= 0.
  - LOCKED, comma in another lane: err++. When err reaches UNLOCK_ERRORS, go to HUNT. The offset is retained.
  - Counters saturate and never wrap.
- Loss of sync:
  - Registered RAW_RXLOSSOFSYNC_IN[1] = 1 forces HUNT from any state, with counters cleared.
  - This takes priority over comma events in the same cycle.
- Status outputs:
  - RXLOSSOFSYNC_OUT[1] = (state != LOCKED) OR delayed raw[1].
  - RXLOSSOFSYNC_OUT[0] = delayed raw[0].
  - Both are delayed to match the data latency.
  - ALIGNED_OUT and ALIGNMENT_OUT change in the same cycle that the output register first uses the new offset.
- Offset change on lock: the bytes in the transition cycle may be duplicated or dropped. RXLOSSOFSYNC_OUT[1] is still 1 in that cycle, so downstream discards them.
- The block has no backpressure. It produces one word per cycle, every cycle.

Test Plan:
- Reset: hold RESET_IN = 0 with random inputs -> outputs stay 0, RXLOSSOFSYNC_OUT = 2'b10, ALIGNED_OUT = 0. Release -> outputs unchanged until a lock occurs.
- Lock on lane 2: send comma 0xBC (K28.5) in lane 2 every 4th word, with incrementing data bytes -> ALIGNED_OUT rises after the 4th comma, ALIGNMENT_OUT = 2. Subsequent RXDATA_OUT has 0xBC in lane 0 with RXCHARISCOMMA_OUT = 4'b0001, 3 cycles after each input comma, and byte order is preserved across word boundaries.
- Competing lanes: commas alternate between lane 1 and lane 3 -> never locks, ALIGNED_OUT stays 0. Then send 4 lane-3 commas -> locks with offset 3.
- Unlock: while locked on lane 0, send 3 lane-1 commas, then 1 lane-0 comma, then 4 lane-1 commas -> stays locked after the 3 (err resets). Drops to HUNT after the 4th consecutive foreign comma, with RXLOSSOFSYNC_OUT[1] = 1.
- GTP loss of sync: while locked, pulse RAW_RXLOSSOFSYNC_IN = 2'b10 for 1 cycle together with a valid comma -> HUNT, ALIGNED_OUT = 0, and a full LOCK_COUNT of commas is required to relock.
- Multi-comma word: commas in lanes 1 and 3 of the same word, repeated -> the block treats lane 1 as the candidate and locks with offset 1.
